// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: one line sample per rx_clk, frame FSM, receive FIFO with overrun tracking.
// Optional parity stage is compiled in with UART_RX_PARITY_EN; DATA_WIDTH defaults to `DATA_WIDTH (uart_params.vh).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_rx_ctrl #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          rx_clk,
  input  logic                          rst_n,
  input  logic                          rx_in,
  input  logic                          rx_en,
  input  logic                          rx_ready,
  input  logic                          ovr_clr,
  output logic                          rx_valid,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          parity_bit_error,
  output logic                          stop_bit_error,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_err_q, par_err_d;
  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  accept;
  logic                  drop;
  logic                  stop_err;
  logic [EW-1:0]         head;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_err_d = par_err_q;
    push      = 1'b0;
    stop_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_en && !rx_in) begin
          state_d   = DATA;
          idx_d     = '0;
          par_err_d = 1'b0;
        end
      end
      DATA: begin
        shreg_d = (shreg_q >> 1) | (DATA_WIDTH'(rx_in) << (DATA_WIDTH - 1));
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      // Unreachable when parity is compiled out, so par_err_q then stays 0.
      PARITY: begin
        par_err_d = rx_in ^ (^shreg_q) ^ ODD;
        state_d   = STOP;
      end
      STOP: begin
        push     = 1'b1;
        stop_err = !rx_in;
        state_d  = rx_in ? IDLE : BRK_WAIT;
      end
      BRK_WAIT: begin
        if (rx_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // A pop at the same edge frees the slot a full-FIFO push needs.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    full   = (count_q == CW'(FIFO_DEPTH));
    pop    = valid_q && rx_ready;
    accept = push && (!full || pop);
    drop   = push && full && !pop;

    if (accept) begin
      mem_d[wr_ptr_q] = {stop_err, par_err_q, shreg_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d = count_q + CW'(accept) - CW'(pop);
    valid_d = (count_d != '0);

    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
    else              overrun_d = overrun_q;
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign rx_valid         = valid_q;
  assign rx_data          = valid_q ? head[DATA_WIDTH-1:0] : '0;
  assign parity_bit_error = valid_q & head[DATA_WIDTH];
  assign stop_bit_error   = valid_q & head[DATA_WIDTH+1];
  assign overrun          = overrun_q;
  assign busy             = busy_q;
  assign fifo_count       = count_q;

endmodule
